mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage. It registers the execute-to-memory bus, selects the load data returned by the data SRAM or the ALU result, and forwards the outcome to write-back over a valid/allow_in handshake. The SRAM returns read data one cycle after the request. While write-back is stalled, the execute stage may present a new SRAM address, so this stage captures the load data in a hold register. It also exports its destination register, load flag and result for hazard detection and bypass in decode.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- es_to_ms_valid  in  1  execute stage presents a valid instruction
- ms_allow_in  out  1  this stage can accept an instruction this cycle
- es_ms_bus  in  71  {pc[70:39], gr_we[38], dest[37:33], alu_result[32:1], res_from_mem[0]}
- data_sram_rdata  in  32  SRAM read data; valid for the request made in the cycle before the instruction's first MEM cycle
- ws_allow_in  in  1  write-back stage can accept
- ms_to_ws_valid  out  1  valid instruction offered to write-back
- ms_ws_bus  out  70  {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}
- ms_dest_reg  out  5  destination register, forced to 0 when the stage is empty
- ms_load  out  1  held instruction is a load (res_from_mem && ms_valid)
- ms_fwd_value  out  32  final_result, for bypass

## Operation
- State:
  - ms_valid
  - bus register: pc, gr_we, dest, alu_result, res_from_mem
  - rdata_buf[31:0]
  - rdata_held
- Handshake:
  - ms_ready_go = 1.
  - ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Valid update: when ms_allow_in, ms_valid <= es_to_ms_valid. Otherwise ms_valid holds.
- Bus capture: when es_to_ms_valid && ms_allow_in, load the bus register from es_ms_bus and clear rdata_held. Otherwise the bus register holds.
- Load-data hold:
  - Trigger: ms_valid && !rdata_held && !(es_to_ms_valid && ms_allow_in).
  - Action: rdata_buf <= data_sram_rdata and rdata_held <= 1.
  - Effect: the instruction's SRAM data is captured exactly on its first MEM cycle. The capture happens only if the instruction is still resident at the end of that cycle.
  - When an instruction leaves and a new one enters on the same edge, the clear of rdata_held wins over the capture.
- Result select:
  - load_data = rdata_held ? rdata_buf : data_sram_rdata.
  - final_result = res_from_mem ? load_data : alu_result.
- Combinational outputs: ms_dest_reg, ms_load and ms_fwd_value are combinational from state plus data_sram_rdata.
- Empty stage: ms_dest_reg and ms_load are 0. ms_ws_bus content is don't-care except when ms_to_ws_valid = 1.
- Scope: word loads only; there is no byte/half extraction. Stores pass through with gr_we as supplied.

## Timing
- Reset values:
  - ms_valid = 0, rdata_held = 0, rdata_buf = 0, bus register = 0.
  - Resulting outputs: ms_to_ws_valid = 0, ms_allow_in = 1, ms_dest_reg = 0, ms_load = 0.
- Latency: one cycle. An instruction accepted at edge N is offered to write-back during cycle N+1.
- Throughput: one instruction per cycle when ws_allow_in stays 1. There are no bubbles inserted by this stage.
- Stall:
  - While ws_allow_in = 0 with ms_valid = 1: ms_allow_in = 0, and the bus register, rdata_buf and ms_valid are frozen after the first capture.
  - ms_ws_bus is stable for the whole stall, even though data_sram_rdata changes.
- Bubble: if ms_allow_in = 1 and es_to_ms_valid = 0, ms_valid clears on the next edge.
- Reset mid-stall: the next edge empties the stage regardless of ws_allow_in or es_to_ms_valid. No output depends on pre-reset state afterwards.

## Test plan
- Reset: assert reset for 2 cycles with es_to_ms_valid = 1 → ms_to_ws_valid = 0, ms_allow_in = 1, ms_dest_reg = 0, ms_load = 0 throughout and after release until the first accept.
- ALU pass-through: send bus {pc=0x1c000000, gr_we=1, dest=5, alu=0x12345678, mem=0} with ws_allow_in = 1 → next cycle ms_ws_bus = {0x1c000000, 1, 5, 0x12345678}, ms_to_ws_valid = 1, ms_dest_reg = 5.
- Load, no stall: send a load with dest=7 and drive rdata = 0xDEADBEEF in its first MEM cycle → final_result = 0xDEADBEEF, ms_load = 1 in that cycle.
- Load under stall:
  - Stimulus: send a load, hold ws_allow_in = 0 for 3 cycles, drive rdata = 0xAAAA5555 in the first MEM cycle and 0x0 afterwards.
  - Required response: final_result stays 0xAAAA5555 for all 4 cycles and ms_allow_in = 0 for the 3 stall cycles.
- Back-to-back loads:
  - Stimulus: two loads on consecutive cycles, rdata 0x11111111 then 0x22222222, ws_allow_in = 1.
  - Required response: write-back sees 0x11111111 then 0x22222222. The second instruction does not inherit the held data.
- Bubble: drop es_to_ms_valid for one cycle between two instructions → ms_to_ws_valid goes 1,0,1 and ms_dest_reg = 0 during the bubble.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, merges SRAM load data
// with the ALU result, and hands the result to write-back over valid/allow_in.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allow_in,
  input  logic [70:0] es_ms_bus,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allow_in,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_ws_bus,
  output logic [4:0]  ms_dest_reg,
  output logic        ms_load,
  output logic [31:0] ms_fwd_value
);

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        res_from_mem;
  } es_ms_bus_t;

  es_ms_bus_t  r_bus;
  logic        r_valid;
  logic [31:0] r_rdata_buf;
  logic        r_rdata_held;

  logic        w_ready_go;
  logic        w_accept;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;

  assign w_ready_go     = 1'b1;
  assign ms_allow_in    = !r_valid || (w_ready_go && ws_allow_in);
  assign ms_to_ws_valid = r_valid && w_ready_go;
  assign w_accept       = es_to_ms_valid && ms_allow_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_bus        <= '0;
      r_rdata_buf  <= '0;
      r_rdata_held <= 1'b0;
    end else begin
      if (ms_allow_in) begin
        r_valid <= es_to_ms_valid;
      end
      // A new instruction entering wins over capturing the departing one's data.
      if (w_accept) begin
        r_bus        <= es_ms_bus;
        r_rdata_held <= 1'b0;
      end else if (r_valid && !r_rdata_held) begin
        r_rdata_buf  <= data_sram_rdata;
        r_rdata_held <= 1'b1;
      end
    end
  end

  // SRAM data is only live in the first MEM cycle; afterwards the held copy is used.
  assign w_load_data    = r_rdata_held ? r_rdata_buf : data_sram_rdata;
  assign w_final_result = r_bus.res_from_mem ? w_load_data : r_bus.alu_result;

  assign ms_ws_bus    = {r_bus.pc, r_bus.gr_we, r_bus.dest, w_final_result};
  assign ms_dest_reg  = r_valid ? r_bus.dest : 5'd0;
  assign ms_load      = r_valid && r_bus.res_from_mem;
  assign ms_fwd_value = w_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, ALU pass-through, loads
// with and without stall, back-to-back loads, bubbles and reset during a stall.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allow_in;
  logic [70:0] es_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_ws_bus;
  logic [4:0]  ms_dest_reg;
  logic        ms_load;
  logic [31:0] ms_fwd_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_allow_in    (ms_allow_in),
    .es_ms_bus      (es_ms_bus),
    .data_sram_rdata(data_sram_rdata),
    .ws_allow_in    (ws_allow_in),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_ws_bus      (ms_ws_bus),
    .ms_dest_reg    (ms_dest_reg),
    .ms_load        (ms_load),
    .ms_fwd_value   (ms_fwd_value)
  );

  function automatic logic [70:0] mk_es(input logic [31:0] pc, input logic we,
                                        input logic [4:0] dest, input logic [31:0] alu,
                                        input logic mem);
    return {pc, we, dest, alu, mem};
  endfunction

  function automatic logic [69:0] mk_ws(input logic [31:0] pc, input logic we,
                                        input logic [4:0] dest, input logic [31:0] res);
    return {pc, we, dest, res};
  endfunction

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 70'(ms_to_ws_valid), 70'(1'b0));
    check({tag, "_allow"}, 70'(ms_allow_in),    70'(1'b1));
    check({tag, "_dest"},  70'(ms_dest_reg),    70'(5'd0));
    check({tag, "_load"},  70'(ms_load),        70'(1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    es_to_ms_valid  = 1'b1;
    es_ms_bus       = mk_es(32'h1c0000f0, 1'b1, 5'd6, 32'h0, 1'b1);
    ws_allow_in     = 1'b1;
    data_sram_rdata = 32'h0;

    // Reset held for two edges while execute offers a valid instruction.
    tick(); #1; check_empty("rst1");
    tick(); reset = 1'b0; es_to_ms_valid = 1'b0; #1; check_empty("rst2");
    tick(); #1; check_empty("idle");

    // ALU pass-through.
    es_to_ms_valid = 1'b1;
    es_ms_bus      = mk_es(32'h1c000000, 1'b1, 5'd5, 32'h12345678, 1'b0);
    tick();
    es_ms_bus = mk_es(32'h1c000004, 1'b1, 5'd7, 32'h00000100, 1'b1);
    #1;
    check("alu_valid", 70'(ms_to_ws_valid), 70'(1'b1));
    check("alu_bus",   ms_ws_bus, mk_ws(32'h1c000000, 1'b1, 5'd5, 32'h12345678));
    check("alu_dest",  70'(ms_dest_reg), 70'(5'd5));
    check("alu_load",  70'(ms_load), 70'(1'b0));

    // Load without stall: live SRAM data in the first MEM cycle.
    tick(); data_sram_rdata = 32'hDEADBEEF; es_to_ms_valid = 1'b0; #1;
    check("ld_fwd",  70'(ms_fwd_value), 70'(32'hDEADBEEF));
    check("ld_load", 70'(ms_load), 70'(1'b1));
    check("ld_dest", 70'(ms_dest_reg), 70'(5'd7));
    check("ld_bus",  ms_ws_bus, mk_ws(32'h1c000004, 1'b1, 5'd7, 32'hDEADBEEF));

    // Bubble between two ALU instructions.
    tick(); data_sram_rdata = 32'h0; #1; check_empty("post_ld");
    es_to_ms_valid = 1'b1;
    es_ms_bus      = mk_es(32'h1c000010, 1'b1, 5'd3, 32'h00000033, 1'b0);
    tick(); es_to_ms_valid = 1'b0; #1;
    check("bub_v1", 70'(ms_to_ws_valid), 70'(1'b1));
    check("bub_d1", 70'(ms_dest_reg), 70'(5'd3));
    tick(); es_to_ms_valid = 1'b1;
    es_ms_bus = mk_es(32'h1c000018, 1'b0, 5'd4, 32'h00000044, 1'b0); #1;
    check("bub_v0", 70'(ms_to_ws_valid), 70'(1'b0));
    check("bub_d0", 70'(ms_dest_reg), 70'(5'd0));
    check("bub_l0", 70'(ms_load), 70'(1'b0));
    tick();
    es_ms_bus = mk_es(32'h1c000100, 1'b1, 5'd9, 32'h00000200, 1'b1); #1;
    check("bub_v2", 70'(ms_to_ws_valid), 70'(1'b1));
    check("bub_d2", 70'(ms_dest_reg), 70'(5'd4));
    check("bub_bus2", ms_ws_bus, mk_ws(32'h1c000018, 1'b0, 5'd4, 32'h00000044));

    // Load under a 3-cycle write-back stall; execute keeps offering a new load.
    tick();
    ws_allow_in = 1'b0; data_sram_rdata = 32'hAAAA5555;
    es_ms_bus   = mk_es(32'h1c000200, 1'b1, 5'd10, 32'h0, 1'b1); #1;
    check("st0_fwd",   70'(ms_fwd_value), 70'(32'hAAAA5555));
    check("st0_allow", 70'(ms_allow_in), 70'(1'b0));
    check("st0_load",  70'(ms_load), 70'(1'b1));
    for (int i = 1; i < 3; i++) begin
      tick(); data_sram_rdata = 32'h0; #1;
      check("stN_fwd",   70'(ms_fwd_value), 70'(32'hAAAA5555));
      check("stN_allow", 70'(ms_allow_in), 70'(1'b0));
      check("stN_bus",   ms_ws_bus, mk_ws(32'h1c000100, 1'b1, 5'd9, 32'hAAAA5555));
    end
    tick(); ws_allow_in = 1'b1; #1;
    check("st3_fwd",   70'(ms_fwd_value), 70'(32'hAAAA5555));
    check("st3_allow", 70'(ms_allow_in), 70'(1'b1));
    check("st3_valid", 70'(ms_to_ws_valid), 70'(1'b1));

    // Back-to-back loads: the second must not see the first's held data.
    tick(); data_sram_rdata = 32'h11111111;
    es_ms_bus = mk_es(32'h1c000204, 1'b1, 5'd11, 32'h0, 1'b1); #1;
    check("b2b1_fwd",  70'(ms_fwd_value), 70'(32'h11111111));
    check("b2b1_dest", 70'(ms_dest_reg), 70'(5'd10));
    tick(); data_sram_rdata = 32'h22222222; es_to_ms_valid = 1'b0; #1;
    check("b2b2_fwd", 70'(ms_fwd_value), 70'(32'h22222222));
    check("b2b2_bus", ms_ws_bus, mk_ws(32'h1c000204, 1'b1, 5'd11, 32'h22222222));

    // Reset during a stall empties the stage on the next edge.
    tick(); es_to_ms_valid = 1'b1;
    es_ms_bus = mk_es(32'h1c000300, 1'b1, 5'd12, 32'h00000055, 1'b0); #1;
    check_empty("pre_rst");
    tick(); ws_allow_in = 1'b0; reset = 1'b1; #1;
    check("rs_valid", 70'(ms_to_ws_valid), 70'(1'b1));
    check("rs_dest",  70'(ms_dest_reg), 70'(5'd12));
    tick(); #1; check_empty("rs_hit");
    reset = 1'b0; es_to_ms_valid = 1'b0; #1; check_empty("rs_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
